// File: rtl/fp_fmt_pkg.sv
// Shared floating-point format constants and stage payload types for the
// FP29i -> FP16 output converter.
//   FP16  : {sign, exp[4:0], frac[9:0]}, bias 15
//   FP16i : 11-bit significand (hidden bit + 10 fraction bits)
//   FP29i : sign, 6-bit biased exponent (bias 31), 22-bit right-aligned mantissa
package fp_fmt_pkg;

  localparam int FP16_EXP_W   = 5;
  localparam int FP16_MAN_W   = 10;
  localparam int FP16_BIAS    = 15;

  localparam int FP16I_MAN_W  = 11;

  localparam int FP29I_EXP_W  = 6;
  localparam int FP29I_MAN_W  = 22;
  localparam int FP29I_BIAS   = 31;

  localparam int LZC_W        = $clog2(FP29I_MAN_W + 1);

  localparam logic [15:0] FP16_PINF = 16'h7C00;
  localparam logic [15:0] FP16_NINF = 16'hFC00;

  // Normalized/denormalized word handed from stage 2 to the round/pack stage.
  // nm[21] is the hidden bit for normals; for subnormals nm is already shifted
  // onto the FP16 subnormal grid and exp is 0.
  typedef struct packed {
    logic                   sgn;
    logic                   zero;
    logic                   ovf;
    logic [FP16_EXP_W-1:0]  exp;
    logic [FP29I_MAN_W-1:0] nm;
    logic                   sticky;
  } fp_norm_t;

  typedef struct packed {
    logic [15:0] fp16;
    logic        ovf;
    logic        unf;
    logic        inexact;
  } fp16_res_t;

endpackage

// File: rtl/bsl.sv
// Logical barrel shift left.
//   i_data : input word
//   i_amt  : shift amount (amounts >= W give 0)
//   o_data : shifted word
module bsl #(
  parameter int W  = 22,
  parameter int SW = 5
) (
  input  logic [W-1:0]  i_data,
  input  logic [SW-1:0] i_amt,
  output logic [W-1:0]  o_data
);

  assign o_data = i_data << i_amt;

endmodule

// File: rtl/bsr.sv
// Logical barrel shift right with sticky collection.
//   i_data   : input word
//   i_amt    : shift amount (amounts >= W give 0 and sticky = |i_data)
//   o_data   : shifted word
//   o_sticky : OR of every bit shifted out
module bsr #(
  parameter int W  = 22,
  parameter int SW = 5
) (
  input  logic [W-1:0]  i_data,
  input  logic [SW-1:0] i_amt,
  output logic [W-1:0]  o_data,
  output logic          o_sticky
);

  logic [W-1:0] w_lost_mask;

  assign o_data      = i_data >> i_amt;
  assign w_lost_mask = ~({W{1'b1}} << i_amt);
  assign o_sticky    = |(i_data & w_lost_mask);

endmodule

// File: rtl/count_lead_zero.sv
// Leading-zero counter.
//   i_data : word to scan (MSB first)
//   o_cnt  : number of leading zeros, W when i_data is all zero
module count_lead_zero #(
  parameter int W  = 22,
  parameter int CW = $clog2(W + 1)
) (
  input  logic [W-1:0]  i_data,
  output logic [CW-1:0] o_cnt
);

  // Scanning upward lets the highest set bit have the final say.
  always_comb begin
    o_cnt = CW'(W);
    for (int i = 0; i < W; i++) begin
      if (i_data[i]) o_cnt = CW'(W - 1 - i);
    end
  end

endmodule

// File: rtl/fp16_round_pack.sv
// Combinational round-and-pack stage: takes a normalized (or pre-shifted
// subnormal) word and produces the FP16 encoding plus status flags.
//   i_norm : stage-2 payload (sign, zero, pre-round overflow, exp field,
//            22-bit significand with hidden bit at [21], prior sticky)
//   o_res  : {fp16, ovf, unf, inexact}
module fp16_round_pack
  import fp_fmt_pkg::*;
#(
  parameter bit ROUND_RNE = 1'b1
) (
  input  fp_norm_t  i_norm,
  output fp16_res_t o_res
);

  // Guard sits just below the FP16 LSB when the 22-bit significand is cut
  // down to the 11-bit FP16i significand.
  localparam int GRD   = FP29I_MAN_W - FP16I_MAN_W - 1;
  localparam int MAG_W = FP16_EXP_W + FP16_MAN_W;

  logic             w_guard;
  logic             w_sticky;
  logic             w_lsb;
  logic             w_inc;
  logic [MAG_W-1:0] w_mag;
  logic             w_rnd_ovf;
  logic             w_unused_hidden;

  assign w_guard         = i_norm.nm[GRD];
  assign w_sticky        = (|i_norm.nm[GRD-1:0]) | i_norm.sticky;
  assign w_lsb           = i_norm.nm[GRD+1];
  assign w_inc           = ROUND_RNE && w_guard && (w_sticky || w_lsb);
  // Hidden bit is implied by the exponent field, so it is not packed.
  assign w_unused_hidden = i_norm.nm[FP29I_MAN_W-1];

  // Adding the increment to {exp, frac} as one integer lets a fraction
  // carry-out bump the exponent, and lets a subnormal roll up to exp=1.
  assign w_mag     = {i_norm.exp, i_norm.nm[FP29I_MAN_W-2 -: FP16_MAN_W]} + MAG_W'(w_inc);
  assign w_rnd_ovf = &w_mag[MAG_W-1 -: FP16_EXP_W];

  always_comb begin
    o_res = '0;
    if (i_norm.zero) begin
      o_res.fp16 = {i_norm.sgn, 15'h0};
    end else if (i_norm.ovf || w_rnd_ovf) begin
      o_res.fp16    = i_norm.sgn ? FP16_NINF : FP16_PINF;
      o_res.ovf     = 1'b1;
      o_res.inexact = 1'b1;
    end else begin
      o_res.fp16    = {i_norm.sgn, w_mag};
      o_res.unf     = (w_mag == '0);
      o_res.inexact = w_guard | w_sticky;
    end
  end

endmodule

// File: rtl/fp29i_to_fp16.sv
// FP29i -> IEEE FP16 output converter, 3-stage valid/ready pipeline.
//   Stage 1: register input; leading-zero count on the registered mantissa.
//   Stage 2: normalize, compute FP16 exponent, denormalize into subnormal
//            range with sticky collection, flag overflow.
//   Stage 3: round (RNE or truncate) and pack; result registered at output.
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   in_valid/in_ready              input handshake
//   in_sgn, in_exp, in_man_dn      FP29i word: (-1)^s * man * 2^(exp-bias-21)
//   out_valid/out_ready            output handshake
//   out_fp16                       FP16 {sign, exp[4:0], frac[9:0]}
//   out_ovf, out_unf, out_inexact  saturated to Inf / nonzero flushed to 0 /
//                                  rounding lost nonzero bits
module fp29i_to_fp16
  import fp_fmt_pkg::*;
#(
  parameter int IN_EXPBIAS  = FP29I_BIAS,
  parameter int OUT_EXPBIAS = FP16_BIAS,
  parameter bit ROUND_RNE   = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   in_sgn,
  input  logic [FP29I_EXP_W-1:0] in_exp,
  input  logic [FP29I_MAN_W-1:0] in_man_dn,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [15:0]            out_fp16,
  output logic                   out_ovf,
  output logic                   out_unf,
  output logic                   out_inexact
);

  localparam int STAGES = 3;

  logic [STAGES:1]        r_vld_pipe;
  logic                   w_en;

  logic                   r1_sgn;
  logic [FP29I_EXP_W-1:0] r1_exp;
  logic [FP29I_MAN_W-1:0] r1_man;

  logic [LZC_W-1:0]       w_lzc;
  logic [FP29I_MAN_W-1:0] w_nm;
  logic [FP29I_MAN_W-1:0] w_nm_sh;
  logic                   w_sh_sticky;
  logic signed [7:0]      w_e;
  logic                   w_sub;
  logic [7:0]             w_rsh_full;
  logic [4:0]             w_rsh;
  fp_norm_t               w_norm;

  fp_norm_t               r2_norm;
  fp16_res_t              w_res;
  fp16_res_t              r3_res;

  // One enable for the whole pipe: bubbles advance too, so spacing between
  // words is preserved and a stall freezes every stage at once.
  assign w_en      = !out_valid || out_ready;
  assign in_ready  = w_en;
  assign out_valid = r_vld_pipe[STAGES];

  // ---------------- stage 1 -> 2 ----------------
  count_lead_zero #(.W(FP29I_MAN_W), .CW(LZC_W)) u_lzc (
    .i_data (r1_man),
    .o_cnt  (w_lzc)
  );

  bsl #(.W(FP29I_MAN_W), .SW(LZC_W)) u_bsl (
    .i_data (r1_man),
    .i_amt  (w_lzc),
    .o_data (w_nm)
  );

  // 8-bit modular arithmetic; the result is read as signed.
  assign w_e = {2'b00, r1_exp} - 8'(IN_EXPBIAS - OUT_EXPBIAS) - 8'(w_lzc);

  assign w_sub      = (w_e <= 8'sd0);
  assign w_rsh_full = 8'd1 - w_e;
  // Any shift past the 22-bit width already clears nm and folds everything
  // into sticky, so clamping to 31 changes nothing.
  assign w_rsh      = !w_sub ? 5'd0 : (w_rsh_full > 8'd31) ? 5'd31 : w_rsh_full[4:0];

  bsr #(.W(FP29I_MAN_W), .SW(5)) u_bsr (
    .i_data   (w_nm),
    .i_amt    (w_rsh),
    .o_data   (w_nm_sh),
    .o_sticky (w_sh_sticky)
  );

  always_comb begin
    w_norm        = '0;
    w_norm.sgn    = r1_sgn;
    w_norm.zero   = (r1_man == '0);
    w_norm.ovf    = !w_sub && (w_e >= 8'sd31);
    w_norm.exp    = w_sub ? '0 : w_e[FP16_EXP_W-1:0];
    w_norm.nm     = w_nm_sh;
    w_norm.sticky = w_sh_sticky;
  end

  // ---------------- stage 2 -> 3 ----------------
  fp16_round_pack #(.ROUND_RNE(ROUND_RNE)) u_rp (
    .i_norm (r2_norm),
    .o_res  (w_res)
  );

  // ---------------- pipeline registers ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld_pipe <= '0;
      r1_sgn     <= 1'b0;
      r1_exp     <= '0;
      r1_man     <= '0;
      r2_norm    <= '0;
      r3_res     <= '0;
    end else if (w_en) begin
      r_vld_pipe <= {r_vld_pipe[STAGES-1:1], in_valid};
      r1_sgn     <= in_sgn;
      r1_exp     <= in_exp;
      r1_man     <= in_man_dn;
      r2_norm    <= w_norm;
      r3_res     <= w_res;
    end
  end

  assign out_fp16    = r3_res.fp16;
  assign out_ovf     = r3_res.ovf;
  assign out_unf     = r3_res.unf;
  assign out_inexact = r3_res.inexact;

endmodule
